uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART Transmitter among NUM_REQ byte producers. It captures one byte from the granted requester and pulses the Transmitter's load and start controls in order. It then tracks the frame through the Transmitter's busy flag and enforces an idle guard gap before the next grant. It sits between on-board byte sources (switch/key logic, status reporters) and the Transmitter; the Receiver is unaffected.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GUARD_CYCLES, 16, idle CLOCK_125_p cycles between end of frame and next grant (>=1)
BUSY_TIMEOUT, 64, max cycles to wait for tx_busy to rise after tx_start (>=2)

Ports:
CLOCK_125_p  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte pending; held until its req_ack
req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i captured
tx_data  out  8  byte presented to Transmitter, stable from LOAD until next LOAD
tx_load  out  1  one-cycle pulse: Transmitter stores tx_data into its send register
tx_start  out  1  one-cycle pulse: Transmitter begins frame
tx_busy  in  1  Transmitter frame in progress
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
active  out  1  high from grant until end of guard gap
timeout_err  out  1  sticky: a tx_start was not followed by tx_busy

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; req_ack=0, tx_data=0, tx_load=0, tx_start=0, grant_id=NUM_REQ-1 (so requester 0 wins first), active=0, timeout_err=0, counters=0. Reset mid-frame abandons the frame; no ack is issued.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE: if any req_valid, pick the first set bit searching from grant_id+1 upward, wrapping modulo NUM_REQ. Same cycle: register grant_id, tx_data<=req_data[sel], req_ack[sel]<=1, active<=1, go to LOAD. If none are valid, stay.
- LOAD: tx_load=1 for exactly this cycle -> START.
- START: tx_start=1 for exactly this cycle; clear the timeout counter -> WAIT_BUSY.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter reaching BUSY_TIMEOUT-1 -> set timeout_err, go to GUARD.
- WAIT_DONE: tx_busy=0 -> GUARD; clear the guard counter.
- GUARD: count GUARD_CYCLES cycles, then go to IDLE with active<=0. The new grant is issued in the IDLE cycle after GUARD, giving a minimum of GUARD_CYCLES+1 idle cycles between frames.
- Grant-to-tx_start latency is 2 cycles (ack in cycle N, tx_load N+1, tx_start N+2).
- req_ack asserts only in the IDLE->LOAD transition. A requester must drop req_valid or present a new byte in the cycle after its ack. The arbiter ignores req_valid outside IDLE.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 frames.
- req_valid dropped before grant: the request is simply not seen. No ack and no error.
- tx_busy already high in IDLE (foreign use): the arbiter does not grant while tx_busy=1.
- timeout_err clears only on reset.
- tx_load, tx_start and req_ack are never high in the same cycle.

Decomposition:
- Package uart_pkg: state encoding constants (IDLE..GUARD), default GUARD_CYCLES/BUSY_TIMEOUT, byte width 8.
- Sub-module rr_pick: combinational round-robin priority selector (inputs req vector, last grant; outputs one-hot and index). Reused later for receive-side routing.

Test Plan:
- Single request: req_valid=4'b0001, byte 8'hB3 -> req_ack[0] pulse, tx_data=8'hB3, tx_load then tx_start on the next two cycles; the Receiver loopback shows 8'hB3 with parity OK.
- All four requesting continuously (8'h11,22,33,44) -> grant order 0,1,2,3,0; each frame's tx_data matches the granted source.
- Requests 1 and 3 only, last grant=1 -> next grant is 3, then 1; grant_id wraps correctly.
- Model tx_busy rising 3 cycles after tx_start, held 100 cycles -> next tx_load no earlier than GUARD_CYCLES+2 cycles after busy falls.
- tx_busy never rises -> timeout_err=1 after 64 cycles in WAIT_BUSY; arbiter returns to IDLE after guard and serves the next request.
- Assert reset during WAIT_DONE -> all outputs at reset values immediately, no req_ack; after release requester 0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side types: arbiter state encoding, byte width and timing defaults.
// id_width() sizes requester index fields so that a single requester still gets one bit.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_GUARD_CYCLES = 16;
  localparam int DEF_BUSY_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    GUARD     = 3'd5
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and Transmitter signals of the TX arbiter; master = arbiter side, slave = environment.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_load;
  logic                      tx_start;
  logic                      tx_busy;
  logic [IDW-1:0]            grant_id;
  logic                      active;
  logic                      timeout_err;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ack, tx_data, tx_load, tx_start, grant_id, active, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ack, tx_data, tx_load, tx_start, grant_id, active, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after 'last', wrapping.
// Zero latency; when nothing is requested 'any' is low and idx holds 'last'.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = last;
    any    = 1'b0;
    pos    = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IDW'((int'(last) + k) % N);
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART Transmitter: ack/capture, then tx_load and tx_start on the next two cycles.
// Requests are only looked at in IDLE with tx_busy low; a guard gap separates consecutive frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input logic               CLOCK_125_p,
  input logic               reset,
  uart_tx_arbiter_if.master bus
);

  localparam int IDW     = id_width(NUM_REQ);
  localparam int CNT_MAX = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  arb_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               load_q, load_d;
  logic               start_q, start_d;
  logic               active_q, active_d;
  logic               terr_q, terr_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req    (bus.req_valid),
    .last   (grant_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // All pulses are registered so ack, load and start land on three consecutive cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    data_d   = data_q;
    ack_d    = '0;
    load_d   = 1'b0;
    start_d  = 1'b0;
    active_d = active_q;
    terr_d   = terr_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !bus.tx_busy) begin
          grant_d  = pick_idx;
          data_d   = bus.req_data[BYTE_W*pick_idx +: BYTE_W];
          ack_d    = pick_onehot;
          active_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_d  = 1'b1;
        state_d = START;
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d   = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= IDW'(NUM_REQ - 1);
      data_q   <= '0;
      ack_q    <= '0;
      load_q   <= 1'b0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      load_q   <= load_d;
      start_q  <= start_d;
      active_q <= active_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_load     = load_q;
  assign bus.tx_start    = start_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences, then random traffic
// against a frame-level scoreboard with a simple Transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int BT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus_if ();

  uart_tx_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .BUSY_TIMEOUT(BT)) dut (
    .CLOCK_125_p (clk),
    .reset       (rst),
    .bus         (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transmitter model: busy rises tx_dly cycles after tx_start and stays tx_len cycles
  int tx_phase = 0, tx_rem = 0, tx_dly = 3, tx_len = 10, fall_step = -1;
  bit m_busy = 0, foreign = 0, never_busy = 0, prev_busy = 0;

  // Frame-level scoreboard for the random phase
  bit rand_mode = 0, in_frame = 0;
  int ready_step = 0, m_last = 0, load_due = -10, start_due = -10;

  typedef struct {
    logic [N-1:0] valid;
    int           exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] mk_byte(input int e, input int i);
    return 8'((e * 37 + i * 71 + 'hB3) & 255);
  endfunction

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_data(input int e);
    for (int i = 0; i < N; i++) bus_if.req_data[8*i +: 8] = mk_byte(e, i);
  endtask

  task automatic tx_model();
    if (tx_phase == 1) begin
      tx_rem--;
      if (tx_rem <= 0) begin
        m_busy   = 1'b1;
        tx_phase = 2;
        tx_rem   = tx_len;
      end
    end else if (tx_phase == 2) begin
      tx_rem--;
      if (tx_rem <= 0) begin
        m_busy    = 1'b0;
        tx_phase  = 0;
        fall_step = cyc;
        if (rand_mode) begin
          in_frame   = 1'b0;
          ready_step = cyc + G + 1;
        end
      end
    end
    if (bus_if.tx_start && !never_busy) begin
      tx_phase = 1;
      tx_rem   = tx_dly;
    end
  endtask

  task automatic rand_step();
    logic [N-1:0] exp_ack;
    int w;
    bit idle_prev;
    exp_ack   = '0;
    w         = -1;
    idle_prev = !in_frame && (cyc - 1 >= ready_step);
    if (idle_prev && bus_if.req_valid != '0 && !prev_busy) begin
      w = rr_ref(bus_if.req_valid, m_last);
      exp_ack[w] = 1'b1;
    end
    chk("rand_ack", bus_if.req_ack, exp_ack);
    if (w >= 0) begin
      chk("rand_data", bus_if.tx_data, bus_if.req_data[8*w +: 8]);
      chk("rand_grant", bus_if.grant_id, w);
      m_last    = w;
      in_frame  = 1'b1;
      load_due  = cyc + 1;
      start_due = cyc + 2;
      tx_dly    = $urandom_range(1, 4);
      tx_len    = $urandom_range(1, 12);
    end
    chk("rand_load", bus_if.tx_load, (cyc == load_due));
    chk("rand_start", bus_if.tx_start, (cyc == start_due));
    for (int i = 0; i < N; i++) begin
      if (bus_if.req_ack[i]) begin
        if ($urandom_range(0, 1) == 1) bus_if.req_data[8*i +: 8] = 8'($urandom);
        else bus_if.req_valid[i] = 1'b0;
      end else if (bus_if.req_valid[i]) begin
        if ($urandom_range(0, 31) == 0) bus_if.req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        bus_if.req_valid[i]        = 1'b1;
        bus_if.req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    prev_busy = bus_if.tx_busy;
    tx_model();
    if (rand_mode) rand_step();
    bus_if.tx_busy = m_busy | foreign;
  endtask

  task automatic wait_ack(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      step();
      if (bus_if.req_ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no req_ack within 400 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      step();
      if (!bus_if.active && tx_phase == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: arbiter still active after 500 cycles", name);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, bus_if.req_ack, 0);
    chk({tag, "_tx_data"}, bus_if.tx_data, 0);
    chk({tag, "_tx_load"}, bus_if.tx_load, 0);
    chk({tag, "_tx_start"}, bus_if.tx_start, 0);
    chk({tag, "_grant_id"}, bus_if.grant_id, N - 1);
    chk({tag, "_active"}, bus_if.active, 0);
    chk({tag, "_timeout_err"}, bus_if.timeout_err, 0);
  endtask

  initial begin
    bit ok;
    int s, t, n, ld;

    tbl[0]  = '{4'b0001, 0};
    tbl[1]  = '{4'b1010, 1};
    tbl[2]  = '{4'b1010, 3};
    tbl[3]  = '{4'b1010, 1};
    tbl[4]  = '{4'b1111, 2};
    tbl[5]  = '{4'b1111, 3};
    tbl[6]  = '{4'b1111, 0};
    tbl[7]  = '{4'b0100, 2};
    tbl[8]  = '{4'b0011, 0};
    tbl[9]  = '{4'b1000, 3};
    tbl[10] = '{4'b1001, 0};
    tbl[11] = '{4'b0110, 1};

    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
    bus_if.tx_busy   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Vector table: arbitration order, captured byte, load/start spacing
    for (int e = 0; e < 12; e++) begin
      set_data(e);
      bus_if.req_valid = tbl[e].valid;
      wait_ack("tbl_ack_wait", ok);
      if (ok) begin
        chk("tbl_ack", bus_if.req_ack, 32'd1 << tbl[e].exp);
        chk("tbl_grant", bus_if.grant_id, tbl[e].exp);
        chk("tbl_data", bus_if.tx_data, mk_byte(e, tbl[e].exp));
        bus_if.req_valid = '0;
        step();
        chk("tbl_load", {bus_if.tx_load, bus_if.tx_start, |bus_if.req_ack}, 3'b100);
        step();
        chk("tbl_start", {bus_if.tx_load, bus_if.tx_start, |bus_if.req_ack}, 3'b010);
      end
      bus_if.req_valid = '0;
      wait_idle("tbl_idle");
    end

    // Guard gap: busy held 100 cycles, then the next tx_load must respect the gap
    tx_dly = 3;
    tx_len = 100;
    set_data(20);
    bus_if.req_valid = 4'b0011;
    wait_ack("guard_first_ack", ok);
    set_data(21);
    fall_step = -1;
    for (int k = 0; k < 400 && fall_step < 0; k++) step();
    ld = -1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus_if.tx_load) begin
        ld = cyc;
        break;
      end
    end
    chk("guard_gap_min", (ld - fall_step >= G + 2), 1);
    chk("guard_gap_max", (ld - fall_step <= G + 3), 1);
    bus_if.req_valid = '0;
    wait_idle("guard_idle");
    tx_len = 10;

    // Busy never rises: sticky timeout, then normal service resumes
    never_busy = 1'b1;
    set_data(30);
    bus_if.req_valid = 4'b0100;
    wait_ack("to_ack", ok);
    bus_if.req_valid = '0;
    s = -1000;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus_if.tx_start) begin
        s = cyc;
        break;
      end
    end
    t = -1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus_if.timeout_err) begin
        t = cyc;
        break;
      end
    end
    chk("timeout_cycles", t - s, BT);
    never_busy = 1'b0;
    set_data(31);
    bus_if.req_valid = 4'b0010;
    wait_ack("to_next_ack", ok);
    chk("to_next_grant", bus_if.req_ack, 4'b0010);
    chk("to_sticky", bus_if.timeout_err, 1);
    bus_if.req_valid = '0;
    wait_idle("to_idle");

    // Foreign use of the Transmitter blocks grants
    foreign = 1'b1;
    bus_if.tx_busy = 1'b1;
    set_data(40);
    bus_if.req_valid = 4'b0001;
    n = 0;
    repeat (30) begin
      step();
      if (bus_if.req_ack != '0) n++;
    end
    chk("foreign_no_grant", n, 0);
    foreign = 1'b0;
    wait_ack("foreign_release", ok);
    chk("foreign_grant", bus_if.req_ack, 4'b0001);
    bus_if.req_valid = '0;
    wait_idle("foreign_idle");

    // Reset during WAIT_DONE
    set_data(50);
    bus_if.req_valid = 4'b0100;
    wait_ack("rst_ack", ok);
    bus_if.req_valid = '0;
    for (int k = 0; k < 50 && !m_busy; k++) step();
    repeat (4) step();
    chk("pre_reset_active", {bus_if.active, m_busy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    m_busy   = 1'b0;
    tx_phase = 0;
    bus_if.tx_busy = 1'b0;
    n = 0;
    repeat (3) begin
      step();
      if (bus_if.req_ack != '0) n++;
    end
    chk("midrst_no_ack", n, 0);
    rst = 1'b0;
    set_data(51);
    bus_if.req_valid = 4'b1111;
    wait_ack("post_rst_ack", ok);
    chk("post_rst_grant", bus_if.req_ack, 4'b0001);
    chk("post_rst_data", bus_if.tx_data, mk_byte(51, 0));
    bus_if.req_valid = '0;
    wait_idle("post_rst_idle");

    // Random traffic against the scoreboard
    in_frame   = 1'b0;
    ready_step = cyc;
    m_last     = 0;
    load_due   = -10;
    start_due  = -10;
    rand_mode  = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
